// File: rtl/mips_cache_pkg.sv
// Shared types and constants for the MIPS data cache: line layout, FSM states,
// and the byte-lane merge used by write hits.
package mips_cache_pkg;

  localparam int NUM_SETS = 8;
  localparam int NUM_WAYS = 4;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = 29;
  localparam int DATA_W   = 32;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [3:0]        lanes);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mips_cache_lru.sv
// Per-set LRU bookkeeping: age update for an accessed way and victim choice
// (first invalid way, otherwise the way whose age is 3).
module mips_cache_lru (
  input  logic [3:0][1:0] i_ages,
  input  logic [3:0]      i_valid,
  input  logic [1:0]      i_way,
  output logic [3:0][1:0] o_ages,
  output logic [1:0]      o_victim
);

  logic [1:0] w_acc_age;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    o_victim = 2'd0;
    for (int w = 0; w < 4; w++) begin
      if (i_ages[w] == 2'd3) o_victim = 2'(w);
    end
    // Walking downward lets the lowest-numbered invalid way win.
    for (int w = 3; w >= 0; w--) begin
      if (!i_valid[w]) o_victim = 2'(w);
    end
  end

  always_comb begin
    w_acc_age = i_ages[i_way];
    o_ages    = i_ages;
    for (int w = 0; w < 4; w++) begin
      if (2'(w) == i_way)            o_ages[w] = 2'd0;
      else if (i_ages[w] < w_acc_age) o_ages[w] = i_ages[w] + 2'd1;
    end
  end

endmodule

// File: rtl/mips_data_cache.sv
// 4-way set-associative, LRU-replaced, one-word-per-line data cache. Hits are
// combinational; misses stall and fill from a word-addressed backing memory.
module mips_data_cache #(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] writedata,
  input  logic [3:0]  byte_en,
  output logic [31:0] readdata,
  output logic        stall,
  output logic [31:0] data_addr,
  input  logic [31:0] data_in,
  input  logic        data_valid
);
  import mips_cache_pkg::*;

  localparam int IDX_W = $clog2(NUM_SETS);

  line_t                      r_lines [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0][1:0]   r_age   [NUM_SETS];
  state_t                     r_state;
  logic [31:0]                r_miss_addr;

  logic [31:0]              w_lookup_addr;
  logic [IDX_W-1:0]         w_idx;
  logic [TAG_W-1:0]         w_tag;
  logic                     w_hit;
  logic [1:0]               w_hit_way;
  logic [31:0]              w_hit_data;
  logic [NUM_WAYS-1:0]      w_valid;
  logic [1:0]               w_victim;
  logic [1:0]               w_acc_way;
  logic [NUM_WAYS-1:0][1:0] w_new_ages;
  logic                     w_rd;
  logic                     w_wr;
  logic                     w_full;
  logic                     w_idle_miss;

  // During a fill the set/tag come from the latched miss address.
  assign w_lookup_addr = (r_state == FILL) ? r_miss_addr : addr;
  assign w_idx         = w_lookup_addr[IDX_W-1:0];
  assign w_tag         = w_lookup_addr[IDX_W +: TAG_W];

  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = 2'd0;
    w_hit_data = '0;
    w_valid    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      w_valid[w] = r_lines[w_idx][w].valid;
      if (r_lines[w_idx][w].valid && (r_lines[w_idx][w].tag == w_tag)) begin
        w_hit      = 1'b1;
        w_hit_way  = 2'(w);
        w_hit_data = r_lines[w_idx][w].data;
      end
    end
  end

  assign w_acc_way = w_hit ? w_hit_way : w_victim;

  mips_cache_lru u_lru (
    .i_ages   (r_age[w_idx]),
    .i_valid  (w_valid),
    .i_way    (w_acc_way),
    .o_ages   (w_new_ages),
    .o_victim (w_victim)
  );

  // Read wins when both strobes are up; a full-word write miss allocates without fetching.
  assign w_rd        = read_en;
  assign w_wr        = write_en && !read_en;
  assign w_full      = &byte_en;
  assign w_idle_miss = (r_state == IDLE) && !w_hit && (w_rd || (w_wr && !w_full));

  assign stall     = rst && ((r_state == FILL) || w_idle_miss);
  assign readdata  = (rst && (r_state == IDLE) && w_hit) ? w_hit_data : 32'd0;
  assign data_addr = rst ? w_lookup_addr : 32'd0;

  // NOTE: the line array is reset as a whole because valid bits must clear and the array is small; ages restart as the way index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_lines[s][w] <= '0;
          r_age[s][w]   <= 2'(w);
        end
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        IDLE: begin
          if (w_rd) begin
            if (w_hit) begin
              r_age[w_idx] <= w_new_ages;
            end else begin
              r_miss_addr <= addr;
              r_state     <= FILL;
            end
          end else if (w_wr) begin
            if (w_hit) begin
              r_lines[w_idx][w_hit_way].data <= merge_bytes(w_hit_data, writedata, byte_en);
              r_age[w_idx]                   <= w_new_ages;
            end else if (w_full) begin
              r_lines[w_idx][w_victim] <= '{valid: 1'b1, tag: w_tag, data: writedata};
              r_age[w_idx]             <= w_new_ages;
            end else begin
              r_miss_addr <= addr;
              r_state     <= FILL;
            end
          end
        end
        FILL: begin
          if (data_valid) begin
            r_lines[w_idx][w_victim] <= '{valid: 1'b1, tag: w_tag, data: data_in};
            r_age[w_idx]             <= w_new_ages;
            r_state                  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_data_cache.sv
// Directed bench for mips_data_cache: scoreboarded reads against a backing
// memory model that answers 0xA500_0000|A three cycles after a request.
module tb_mips_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        read_en;
  logic        write_en;
  logic [31:0] writedata;
  logic [3:0]  byte_en;
  logic [31:0] readdata;
  logic        stall;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        data_valid;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_q[$];

  mips_data_cache dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .read_en    (read_en),
    .write_en   (write_en),
    .writedata  (writedata),
    .byte_en    (byte_en),
    .readdata   (readdata),
    .stall      (stall),
    .data_addr  (data_addr),
    .data_in    (data_in),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  // Backing memory: data_valid in the 4th consecutive stall cycle (3 cycles after the request).
  initial begin
    int cnt;
    cnt        = 0;
    data_valid = 1'b0;
    data_in    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (stall) begin
        cnt++;
        data_valid = (cnt >= 4);
        data_in    = 32'hA500_0000 | data_addr;
      end else begin
        cnt        = 0;
        data_valid = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    read_en  = 1'b0;
    write_en = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a, input int exp_stalls);
    int n;
    bit done;
    addr     = a;
    read_en  = 1'b1;
    write_en = 1'b0;
    exp_q.push_back(32'hA500_0000 | a);
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      #3;
      if (stall) begin
        n++;
        if (n == 1) check("miss_data_addr", data_addr, a);
        @(negedge clk);
      end else begin
        check("read_data", readdata, exp_q.pop_front());
        check("read_stalls", 32'(n), 32'(exp_stalls));
        done = 1'b1;
      end
    end
    if (!done) check("read_stall_budget", {31'd0, stall}, 32'd0);
    @(negedge clk);
    read_en = 1'b0;
  endtask

  task automatic do_read_exp(input logic [31:0] a, input logic [31:0] exp, input int exp_stalls);
    int n;
    bit done;
    addr     = a;
    read_en  = 1'b1;
    write_en = 1'b0;
    exp_q.push_back(exp);
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      #3;
      if (stall) begin
        n++;
        @(negedge clk);
      end else begin
        check("read_data", readdata, exp_q.pop_front());
        check("read_stalls", 32'(n), 32'(exp_stalls));
        done = 1'b1;
      end
    end
    if (!done) check("read_stall_budget", {31'd0, stall}, 32'd0);
    @(negedge clk);
    read_en = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input int exp_stalls);
    int n;
    bit done;
    addr      = a;
    writedata = wd;
    byte_en   = be;
    write_en  = 1'b1;
    read_en   = 1'b0;
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      #3;
      if (stall) begin
        n++;
        @(negedge clk);
      end else begin
        check("write_stalls", 32'(n), 32'(exp_stalls));
        done = 1'b1;
      end
    end
    if (!done) check("write_stall_budget", {31'd0, stall}, 32'd0);
    @(negedge clk);
    write_en = 1'b0;
  endtask

  initial begin
    int lru_seq[10];
    int lru_stl[10];
    lru_seq = '{8, 16, 24, 32, 40, 16, 32, 48, 24, 16};
    lru_stl = '{0, 0, 0, 4, 4, 0, 0, 4, 4, 0};

    // Reset with a pending read miss on the inputs: outputs must still read zero.
    rst       = 1'b0;
    addr      = 32'h0000_1234;
    read_en   = 1'b1;
    write_en  = 1'b0;
    writedata = '0;
    byte_en   = 4'hF;
    #3;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_readdata", readdata, 32'd0);
    check("reset_data_addr", data_addr, 32'd0);
    read_en = 1'b0;
    addr    = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 8; a++) do_read(32'(a), 4);
    for (int a = 0; a < 8; a++) do_read(32'(a), 0);

    do_reset();
    for (int a = 0; a < 32; a += 8) do_read(32'(a), 4);
    for (int a = 0; a < 32; a += 8) do_read(32'(a), 0);
    for (int i = 0; i < 10; i++) do_read(32'(lru_seq[i]), lru_stl[i]);

    do_read(32'd5, 4);
    do_write(32'd5, 32'hDEAD_BEEF, 4'b0011, 0);
    do_read_exp(32'd5, 32'hA500_BEEF, 0);

    do_write(32'd100, 32'hCAFE_F00D, 4'b1111, 0);
    do_read_exp(32'd100, 32'hCAFE_F00D, 0);

    do_write(32'd101, 32'h1234_5678, 4'b1000, 4);
    do_read_exp(32'd101, 32'h1200_0065, 0);

    // Both strobes high: read wins, write data must not land.
    addr      = 32'd100;
    writedata = 32'h0BAD_0BAD;
    byte_en   = 4'hF;
    read_en   = 1'b1;
    write_en  = 1'b1;
    #3;
    check("rw_priority_read", readdata, 32'hCAFE_F00D);
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    do_read_exp(32'd100, 32'hCAFE_F00D, 0);

    // Reset in the middle of a fill.
    addr    = 32'd200;
    read_en = 1'b1;
    #3;
    check("midfill_stall_before", {31'd0, stall}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midfill_stall_reset", {31'd0, stall}, 32'd0);
    check("midfill_readdata_reset", readdata, 32'd0);
    check("midfill_data_addr_reset", data_addr, 32'd0);
    read_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_read(32'd200, 4);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
